spi_sclk_engine: RTL

- Parametrised SCLK and transfer-timing engine for the APB-SPI controller; next generation of the baud generator.
- Derives SCLK from PCLK using the SPPR/SPR divisor and supports all four CPOL/CPHA modes.
- Counts a programmable number of bits per transfer and gives the shift register registered shift/sample strobes plus a start/busy/done handshake.
- Adds abort, wait-mode freeze and a bit counter.

---
 rtl/spi_sclk_engine.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/spi_sclk_engine.sv
// SCLK and transfer-timing engine for the APB-SPI controller: divides PCLK by the
// SPPR/SPR divisor, sequences len SCLK periods in any CPOL/CPHA mode and strobes the shifter.
module spi_sclk_engine #(
    parameter int SPPR_W   = 3,
    parameter int SPR_W    = 3,
    parameter int DIV_W    = 12,
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = 6
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [SPPR_W-1:0] sppr_i,
    input  logic [SPR_W-1:0] spr_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic [1:0]       spi_mode_i,
    input  logic             spiswai_i,
    output logic             sclk_o,
    output logic             shift_o,
    output logic             sample_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] bit_cnt_o,
    output logic [DIV_W-1:0] divisor_o
);

    localparam int EC_W = LEN_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    hcnt_q, hcnt_d;
    logic [EC_W-1:0]     edge_cnt_q, edge_cnt_d;
    logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [SPPR_W-1:0]   sppr_q, sppr_d;
    logic [SPR_W-1:0]    spr_q, spr_d;
    logic                cpha_q, cpha_d;
    logic                sclk_q, sclk_d;
    logic                shift_q, shift_d;
    logic                sample_q, sample_d;
    logic                done_q, done_d;

    logic                run;
    logic                len_ok;
    logic                accept;
    logic                tick;
    logic                last_edge;
    logic [DIV_W-1:0]    half_per;
    logic [DIV_W-1:0]    half_live;

    assign run       = (spi_mode_i == 2'b00) || (spi_mode_i == 2'b01 && !spiswai_i);
    assign len_ok    = (len_i != '0) && (len_i <= MAX_LEN);
    assign accept    = (state_q == IDLE) && start_i && run && len_ok;

    // Half period uses the configuration captured at accept; divisor_o follows the live pins.
    assign half_per  = (DIV_W'(sppr_q) + DIV_W'(1)) << spr_q;
    assign half_live = (DIV_W'(sppr_i) + DIV_W'(1)) << spr_i;
    assign divisor_o = half_live << 1;

    assign tick      = (hcnt_q == half_per - DIV_W'(1));
    assign last_edge = (edge_cnt_q == ({len_q, 1'b0} - EC_W'(1)));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            len_q      <= '0;
            sppr_q     <= '0;
            spr_q      <= '0;
            cpha_q     <= 1'b0;
            sclk_q     <= cpol_i;
            shift_q    <= 1'b0;
            sample_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            len_q      <= len_d;
            sppr_q     <= sppr_d;
            spr_q      <= spr_d;
            cpha_q     <= cpha_d;
            sclk_q     <= sclk_d;
            shift_q    <= shift_d;
            sample_q   <= sample_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (run && tick && last_edge) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hcnt_d     = hcnt_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        len_d      = len_q;
        sppr_d     = sppr_q;
        spr_d      = spr_q;
        cpha_d     = cpha_q;
        sclk_d     = sclk_q;
        shift_d    = 1'b0;
        sample_d   = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                sclk_d = cpol_i;
                if (accept) begin
                    len_d      = len_i;
                    sppr_d     = sppr_i;
                    spr_d      = spr_i;
                    cpha_d     = cpha_i;
                    hcnt_d     = '0;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shift_d    = !cpha_i;
                end
            end
            ACTIVE: begin
                if (abort_i) begin
                    sclk_d = cpol_i;
                end else if (run) begin
                    if (tick) begin
                        hcnt_d     = '0;
                        sclk_d     = !sclk_q;
                        edge_cnt_d = edge_cnt_q + EC_W'(1);
                        // Even count before the increment marks a leading edge.
                        if (!edge_cnt_q[0]) begin
                            shift_d  = cpha_q;
                            sample_d = !cpha_q;
                        end else begin
                            bit_cnt_d = bit_cnt_q + LEN_W'(1);
                            sample_d  = cpha_q;
                            shift_d   = !cpha_q && !last_edge;
                            done_d    = last_edge;
                        end
                    end else begin
                        hcnt_d = hcnt_q + DIV_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign sclk_o    = sclk_q;
    assign shift_o   = shift_q;
    assign sample_o  = sample_q;
    assign busy_o    = (state_q == ACTIVE);
    assign done_o    = done_q;
    assign bit_cnt_o = bit_cnt_q;

endmodule
